// File: rtl/lcd_arb_pkg.sv
// lcd_arb_pkg: shared FSM states, source ids and PS/2 constants for the LCD write arbiter
package lcd_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;
    localparam logic SRC_KBD = 1'b0;
    localparam logic SRC_CPU = 1'b1;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
endpackage

// File: rtl/lcd_write_arbiter_if.sv
// lcd_write_arbiter_if: keyboard, processor and LCD signals of the arbiter
//   master: drives kbd_valid/kbd_data and cpu_wr_en/cpu_wr_data
//   master: observes cpu_ready, lcd_wr_en/lcd_wr_data, grant_src and kbd_overflow
//   slave:  the arbiter side of the same signals
interface lcd_write_arbiter_if;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        cpu_wr_en;
    logic [31:0] cpu_wr_data;
    logic        cpu_ready;
    logic        lcd_wr_en;
    logic [7:0]  lcd_wr_data;
    logic        grant_src;
    logic        kbd_overflow;
    modport master (
        output kbd_valid, kbd_data, cpu_wr_en, cpu_wr_data,
        input  cpu_ready, lcd_wr_en, lcd_wr_data, grant_src, kbd_overflow
    );
    modport slave (
        input  kbd_valid, kbd_data, cpu_wr_en, cpu_wr_data,
        output cpu_ready, lcd_wr_en, lcd_wr_data, grant_src, kbd_overflow
    );
endinterface

// File: rtl/lcd_arb_fifo.sv
// lcd_arb_fifo: synchronous FIFO buffering keyboard bytes
//   in:  clock, reset, push/push_data, pop
//   out: pop_data (head entry), empty, full
module lcd_arb_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic do_push, do_pop;
    // The pointers carry one extra MSB, so equal pointers mean empty and
    // pointers differing only in that MSB mean full.
    always_comb begin
        empty = wr_q == rd_q;
        full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d = wr_q + {{AW{1'b0}}, do_push};
        rd_d = rd_q + {{AW{1'b0}}, do_pop};
        pop_data = mem_q[rd_q[AW-1:0]];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: shares the LCD controller between the processor and the PS/2 keyboard echo
//   in:  clock, reset (sync, active high)
//   bus: kbd_valid/kbd_data, cpu_wr_en/cpu_wr_data in; cpu_ready, lcd_wr_en/lcd_wr_data,
//        grant_src, kbd_overflow out
module lcd_write_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 64,
    parameter bit DROP_BREAK = 1'b1
) (
    input logic clock,
    input logic reset,
    lcd_write_arbiter_if.slave bus
);
    localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic hold_valid_q, hold_valid_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic skip_q, skip_d;
    logic overflow_q, overflow_d;
    logic lcd_wr_en_q, lcd_wr_en_d;
    logic [7:0] lcd_wr_data_q, lcd_wr_data_d;
    logic grant_q, grant_d;
    logic push, pop, start, winner, accept;
    logic fifo_empty, fifo_full;
    logic [7:0] fifo_data;
    logic unused_cpu_hi;
    assign unused_cpu_hi = ^bus.cpu_wr_data[31:8];
    lcd_arb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .push_data(bus.kbd_data),
        .pop(pop),
        .pop_data(fifo_data),
        .empty(fifo_empty),
        .full(fifo_full)
    );
    always_comb begin
        // A break code and the byte following it never reach the FIFO.
        push = bus.kbd_valid && !(DROP_BREAK && (skip_q || bus.kbd_data == PS2_BREAK));
        skip_d = DROP_BREAK && bus.kbd_valid ? !skip_q && bus.kbd_data == PS2_BREAK : skip_q;
        // grant_q doubles as last_grant: on a tie the other source wins.
        winner = !fifo_empty && hold_valid_q ? !grant_q : hold_valid_q;
        start = state_q == ST_IDLE && (!fifo_empty || hold_valid_q);
        pop = start && winner == SRC_KBD;
        overflow_d = overflow_q || (push && fifo_full && !pop);
        accept = bus.cpu_wr_en && !hold_valid_q;
        hold_valid_d = accept ? 1'b1 : start && winner == SRC_CPU ? 1'b0 : hold_valid_q;
        hold_data_d = accept ? bus.cpu_wr_data[7:0] : hold_data_q;
        state_d = state_q;
        cnt_d = cnt_q;
        lcd_wr_en_d = 1'b0;
        lcd_wr_data_d = lcd_wr_data_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_ISSUE;
                lcd_wr_en_d = 1'b1;
                lcd_wr_data_d = winner == SRC_CPU ? hold_data_q : fifo_data;
                grant_d = winner;
            end
            ST_ISSUE: begin
                state_d = ST_GAP;
                cnt_d = GAP_LAST;
            end
            default: begin
                state_d = cnt_q == '0 ? ST_IDLE : ST_GAP;
                cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            end
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q <= '0;
            skip_q <= 1'b0;
            overflow_q <= 1'b0;
            lcd_wr_en_q <= 1'b0;
            lcd_wr_data_q <= '0;
            grant_q <= SRC_KBD;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q <= hold_data_d;
            skip_q <= skip_d;
            overflow_q <= overflow_d;
            lcd_wr_en_q <= lcd_wr_en_d;
            lcd_wr_data_q <= lcd_wr_data_d;
            grant_q <= grant_d;
        end
    end
    assign bus.cpu_ready = !hold_valid_q;
    assign bus.lcd_wr_en = lcd_wr_en_q;
    assign bus.lcd_wr_data = lcd_wr_data_q;
    assign bus.grant_src = grant_q;
    assign bus.kbd_overflow = overflow_q;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: scoreboard bench for lcd_write_arbiter
module tb_lcd_write_arbiter;
    import lcd_arb_pkg::*;
    localparam int GAP = 64;
    localparam int DEPTH = 8;
    localparam int SPACING = GAP + 2;
    typedef struct packed {
        logic [7:0] data;
        logic       src;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    exp_t exp_q[$];
    exp_t e;
    int strobe_cyc[$];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    always #5 clock = ~clock;
    lcd_write_arbiter_if bus();
    lcd_write_arbiter #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .DROP_BREAK(1'b1)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    always @(posedge clock) cyc <= cyc + 1;
    // Every strobe must match the oldest expected write, in data and source.
    always @(negedge clock) begin
        if (!reset && bus.lcd_wr_en) begin
            strobe_cyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected: got data=%h src=%b, required no strobe", bus.lcd_wr_data, bus.grant_src);
            end else begin
                e = exp_q.pop_front();
                if ({bus.lcd_wr_data, bus.grant_src} !== e) begin
                    bad++;
                    $display("FAIL strobe_order: got data=%h src=%b, required data=%h src=%b", bus.lcd_wr_data, bus.grant_src, e.data, e.src);
                end
            end
        end
    end
    task automatic do_reset();
        bus.kbd_valid = 1'b0;
        bus.kbd_data = 8'h00;
        bus.cpu_wr_en = 1'b0;
        bus.cpu_wr_data = 32'h0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        strobe_cyc.delete();
    endtask
    task automatic kbd_byte(input logic [7:0] b);
        bus.kbd_valid = 1'b1;
        bus.kbd_data = b;
        @(negedge clock);
        bus.kbd_valid = 1'b0;
    endtask
    task automatic cpu_write(input logic [31:0] d);
        bus.cpu_wr_en = 1'b1;
        bus.cpu_wr_data = d;
        @(negedge clock);
        bus.cpu_wr_en = 1'b0;
    endtask
    // Waits for the scoreboard to empty, then idles one spacing window so a stray strobe is seen.
    task automatic drain(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        repeat (SPACING) @(negedge clock);
    endtask
    task automatic find_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.lcd_wr_en) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask
    task automatic test_reset();
        do_reset();
        total++; if (bus.lcd_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b, required 0", bus.lcd_wr_en); end
        total++; if (bus.lcd_wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data: got %h, required 00", bus.lcd_wr_data); end
        total++; if (bus.grant_src !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b, required 0", bus.grant_src); end
        total++; if (bus.kbd_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b, required 0", bus.kbd_overflow); end
        total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", bus.cpu_ready); end
    endtask
    task automatic test_single_cpu();
        bit ok;
        do_reset();
        exp_q.push_back({8'h41, SRC_CPU});
        cpu_write(32'h0000_0041);
        total++; if (bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL cpu_ready_after_accept: got %b, required 0", bus.cpu_ready); end
        total++; if (bus.lcd_wr_en !== 1'b0) begin bad++; $display("FAIL cpu_early_strobe: got %b, required 0", bus.lcd_wr_en); end
        @(negedge clock);
        total++; if (bus.lcd_wr_en !== 1'b1) begin bad++; $display("FAIL cpu_strobe: got %b, required 1", bus.lcd_wr_en); end
        total++; if (bus.lcd_wr_data !== 8'h41) begin bad++; $display("FAIL cpu_data: got %h, required 41", bus.lcd_wr_data); end
        total++; if (bus.grant_src !== 1'b1) begin bad++; $display("FAIL cpu_grant: got %b, required 1", bus.grant_src); end
        total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL cpu_ready_after_issue: got %b, required 1", bus.cpu_ready); end
        drain(2 * SPACING, ok);
        total++; if (!ok) begin bad++; $display("FAIL cpu_drain: %0d writes pending, required 0", exp_q.size()); end
    endtask
    task automatic test_tie();
        bit ok;
        do_reset();
        exp_q.push_back({8'h42, SRC_CPU});
        exp_q.push_back({8'h1C, SRC_KBD});
        bus.kbd_valid = 1'b1;
        bus.kbd_data = 8'h1C;
        bus.cpu_wr_en = 1'b1;
        bus.cpu_wr_data = 32'hDEAD_BE42;
        @(negedge clock);
        bus.kbd_valid = 1'b0;
        bus.cpu_wr_en = 1'b0;
        drain(4 * SPACING, ok);
        total++; if (!ok) begin bad++; $display("FAIL tie_drain: %0d writes pending, required 0", exp_q.size()); end
        total++;
        if (strobe_cyc.size() != 2) begin
            bad++; $display("FAIL tie_strobe_count: got %0d, required 2", strobe_cyc.size());
        end else if (strobe_cyc[1] - strobe_cyc[0] != SPACING) begin
            bad++; $display("FAIL tie_spacing: got %0d, required %0d", strobe_cyc[1] - strobe_cyc[0], SPACING);
        end
    endtask
    task automatic test_break_filter();
        bit ok;
        logic [7:0] seq [4];
        seq = '{8'h1C, 8'hF0, 8'h1C, 8'h32};
        do_reset();
        exp_q.push_back({8'h1C, SRC_KBD});
        exp_q.push_back({8'h32, SRC_KBD});
        for (int i = 0; i < 4; i++) begin
            kbd_byte(seq[i]);
            @(negedge clock);
        end
        drain(4 * SPACING, ok);
        total++; if (!ok) begin bad++; $display("FAIL break_drain: %0d writes pending, required 0", exp_q.size()); end
        total++; if (strobe_cyc.size() != 2) begin bad++; $display("FAIL break_count: got %0d strobes, required 2", strobe_cyc.size()); end
    endtask
    task automatic test_overflow();
        bit ok;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back({8'(8'h10 + i), SRC_KBD});
            if (i == 9) begin
                total++; if (bus.kbd_overflow !== 1'b0) begin bad++; $display("FAIL ovf_before_drop: got %b, required 0", bus.kbd_overflow); end
            end
            kbd_byte(8'(8'h10 + i));
            @(negedge clock);
        end
        total++; if (bus.kbd_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b, required 1", bus.kbd_overflow); end
        drain(10 * SPACING, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_drain: %0d writes pending, required 0", exp_q.size()); end
        total++; if (bus.kbd_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, required 1", bus.kbd_overflow); end
    endtask
    task automatic test_full_pop();
        bit ok;
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back({8'(8'h20 + i), SRC_KBD});
        kbd_byte(8'h20);
        find_strobe(ok);
        total++; if (!ok) begin bad++; $display("FAIL full_first_strobe: got none, required strobe within 10 cycles"); end
        for (int i = 1; i < 9; i++) kbd_byte(8'(8'h20 + i));
        // Now 8 cycles after the strobe; the IDLE->ISSUE edge ends cycle strobe+GAP+1.
        repeat (GAP + 1 - 8) @(negedge clock);
        kbd_byte(8'h29);
        total++; if (bus.kbd_overflow !== 1'b0) begin bad++; $display("FAIL full_pop_overflow: got %b, required 0", bus.kbd_overflow); end
        drain(12 * SPACING, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_drain: %0d writes pending, required 0", exp_q.size()); end
        total++; if (bus.kbd_overflow !== 1'b0) begin bad++; $display("FAIL full_overflow_end: got %b, required 0", bus.kbd_overflow); end
    endtask
    task automatic test_reset_mid();
        bit ok;
        do_reset();
        exp_q.push_back({8'h30, SRC_CPU});
        cpu_write(32'h0000_0030);
        find_strobe(ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_first_strobe: got none, required strobe within 10 cycles"); end
        @(negedge clock);
        kbd_byte(8'h31);
        kbd_byte(8'h32);
        kbd_byte(8'h33);
        cpu_write(32'h0000_0055);
        repeat (10) @(negedge clock);
        total++; if (bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL mid_hold_pending: got ready=%b, required 0", bus.cpu_ready); end
        reset = 1'b1;
        @(negedge clock);
        total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b, required 1", bus.cpu_ready); end
        total++; if (bus.lcd_wr_data !== 8'h00) begin bad++; $display("FAIL mid_reset_data: got %h, required 00", bus.lcd_wr_data); end
        total++; if (bus.grant_src !== 1'b0) begin bad++; $display("FAIL mid_reset_grant: got %b, required 0", bus.grant_src); end
        reset = 1'b0;
        exp_q.delete();
        strobe_cyc.delete();
        repeat (3 * SPACING) @(negedge clock);
        total++; if (strobe_cyc.size() != 0) begin bad++; $display("FAIL mid_no_strobe: got %0d strobes, required 0", strobe_cyc.size()); end
        total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_end: got %b, required 1", bus.cpu_ready); end
    endtask
    initial begin
        test_reset();
        test_single_cpu();
        test_tie();
        test_break_filter();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
